trace_gen: RTL and testbench
============================

# trace_gen

Address-trace source for the cache hit-rate block. It produces memory addresses and per-address `trace_ready` strobes on the same interface the cache consumes. Software or the bench loads a pattern descriptor (sequential, looping working-set, or pseudo-random) and pulses `start`. The block then emits `count` addresses at a programmable pace and reports progress through `busy`, `done` and `issued`.

## Interface

Parameters:
- `ADDR_W`, default 32: address width; must match the cache `mem_addr` width.
- `CNT_W`, default 20: width of the `issued` counter; matches the cache hit-counter width.

Ports (`name  direction  width  meaning`):
- `clk`  in  1  single clock.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  pulse; latches the descriptor and begins a run. Ignored while `busy`.
- `mode`  in  2  0 = SEQ, 1 = LOOP, 2 = RAND, 3 = reserved (behaves as SEQ).
- `base_addr`  in  ADDR_W  first/base address.
- `stride`  in  16  address increment in SEQ and LOOP, zero-extended.
- `window`  in  16  LOOP wrap limit; RAND mask is `window-1`. `window=0` means 0x10000.
- `count`  in  16  number of addresses to emit.
- `gap`  in  4  idle cycles between consecutive strobes.
- `seed`  in  32  RAND LFSR seed; 0 is replaced by 1.
- `pause`  in  1  level; freezes issue while high.
- `trace_ready`  out  1  one-cycle strobe; `mem_addr` is valid while it is high.
- `mem_addr`  out  ADDR_W  emitted address, registered.
- `busy`  out  1  high in ISSUE/GAP.
- `done`  out  1  level, high in DONE until the next accepted `start`.
- `issued`  out  CNT_W  strobes emitted this run; saturates at all-ones.

## Operation

- FSM states: IDLE, ISSUE, GAP, DONE.
  - IDLE/DONE + `start`: latch `mode`, `base_addr`, `stride`, `window`, `count`, `gap`, `seed`. Clear `issued` and `done`, and set offset to 0 and the LFSR to the seed. Go to ISSUE; if `count`=0, go to DONE instead.
  - ISSUE with `pause`=0: drive `trace_ready`=1 and `mem_addr` for index k, then advance state, increment `issued` and decrement the remaining count. If remaining=0 go to DONE; else if `gap`>0 go to GAP; else stay in ISSUE.
  - ISSUE with `pause`=1: `trace_ready`=0 and nothing advances.
  - GAP: count `gap` cycles with `trace_ready`=0, then return to ISSUE. `pause` does not extend GAP but holds the following ISSUE.
- Address generation (all sums are modulo 2^ADDR_W):
  - SEQ: `mem_addr` = base + offset; then offset += stride.
  - LOOP: `mem_addr` = base + offset; then next = offset + stride, and offset = (next >= window) ? 0 : next.
  - RAND: `mem_addr` = base + (lfsr[15:0] & (window-1)). Then the LFSR steps as a right-shift Galois LFSR with toggle mask 0x80200003 (x^32+x^22+x^2+x+1). `window` must be a power of two.
- `mem_addr` holds its last value outside strobes.
- `start` while `busy` is ignored; the latched descriptor does not change mid-run.

## Timing

- Reset values: `trace_ready`=0, `mem_addr`=0, `busy`=0, `done`=0, `issued`=0, FSM=IDLE, LFSR=1.
- Latency: `start` at cycle N gives the first strobe at N+1, provided `pause`=0.
- Strobe period is `gap`+1 cycles. `gap`=0 gives back-to-back strobes.
- `done` rises the cycle after the last strobe, and `busy` falls in the same cycle.
- `count`=0: `done` rises at N+1 and no strobe is emitted.
- Reset asserted mid-run: all outputs return to reset values on the next edge.
- No backpressure from the cache. Each strobe is consumed exactly once.

## Configuration

- `TRACE_GEN_LFSR_EN` defined: the LFSR and RAND mode are present.
- `TRACE_GEN_LFSR_EN` undefined: no LFSR logic, `seed` is unused, and `mode`=2 behaves exactly as SEQ.

## Test plan

- SEQ: base 0x1000, stride 4, count 4, gap 0 -> strobes on 4 consecutive cycles starting N+1, addresses 0x1000, 0x1004, 0x1008, 0x100C. Then `done`=1, `busy`=0, `issued`=4.
- LOOP: base 0x2000, stride 0x40, window 0x100, count 6 -> 0x2000, 0x2040, 0x2080, 0x20C0, 0x2000, 0x2040.
- Pacing/pause: gap 2, count 3 -> strobes at N+1, N+4, N+7. Holding `pause` high for 5 cycles before the second strobe delays it to N+9. A `start` pulse mid-run is ignored.
- RAND (macro on): base 0x3000, seed 0, window 0x100 -> 0x3001, then 0x3003. With the macro off, the same stimulus and stride 4 gives 0x3000, 0x3004.
- Boundaries: count 0 -> no strobe and `done` at N+1. SEQ base 0xFFFFFFFC, stride 8 -> 0xFFFFFFFC, then 0x00000004.
- Reset mid-run after 2 of 10 strobes -> next cycle all outputs 0 and FSM in IDLE. A new `start` restarts from base.

Source files
------------

// File: rtl/trace_gen.sv
// Address-trace source: emits `count` addresses (SEQ / LOOP / RAND) as one-cycle
// strobes at a programmable pace. RAND mode and its LFSR exist only with TRACE_GEN_LFSR_EN.
module trace_gen #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [15:0]       stride,
    input  logic [15:0]       window,
    input  logic [15:0]       count,
    input  logic [3:0]        gap,
    input  logic [31:0]       seed,
    input  logic              pause,
    output logic              trace_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  issued
);
    // state  | meaning
    // IDLE   | waiting for the first start after reset
    // ISSUE  | strobe cycle when trace_ready=1, otherwise held by pause
    // GAP    | idle spacing between strobes
    // DONE   | run finished, done held until the next accepted start
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DONE} state_t;

    localparam logic [1:0] M_LOOP = 2'd1;

    state_t            state_q;
    logic [1:0]        mode_q;
    logic [ADDR_W-1:0] base_q, offset_q, mem_addr_q;
    logic [15:0]       stride_q, window_q, remaining_q;
    logic [3:0]        gap_q, gap_cnt_q;
    logic [CNT_W-1:0]  issued_q;
    logic              trace_ready_q, done_q;

    logic              accept, issue_slot, emit;
    logic [1:0]        cur_mode;
    logic [ADDR_W-1:0] cur_base, cur_off, off_step, off_d, addr_d;
    logic [15:0]       cur_stride, cur_window, cur_remaining;
    logic [16:0]       win_ext;

`ifdef TRACE_GEN_LFSR_EN
    localparam logic [1:0] M_RAND = 2'd2;
    logic [31:0] lfsr_q, cur_lfsr, lfsr_d, seed_nz;
`else
    logic unused_seed;
    assign unused_seed = ^seed;
`endif

    // A start from IDLE/DONE is folded into the same edge so the first strobe appears at N+1.
    always_comb begin
        accept        = ((state_q == S_IDLE) || (state_q == S_DONE)) && start;
        cur_mode      = accept ? mode      : mode_q;
        cur_base      = accept ? base_addr : base_q;
        cur_stride    = accept ? stride    : stride_q;
        cur_window    = accept ? window    : window_q;
        cur_remaining = accept ? count     : remaining_q;
        cur_off       = accept ? '0        : offset_q;
        issue_slot    = (accept && (count != 16'd0))
                     || ((state_q == S_ISSUE)
                         && (!trace_ready_q || ((remaining_q != 16'd0) && (gap_q == 4'd0))))
                     || ((state_q == S_GAP) && (gap_cnt_q == 4'd1));
        emit          = issue_slot && !pause;
        off_step      = cur_off + ADDR_W'(cur_stride);
        win_ext       = (cur_window == 16'd0) ? 17'h10000 : {1'b0, cur_window};
        addr_d        = cur_base + cur_off;
        off_d         = off_step;
        if ((cur_mode == M_LOOP) && ({1'b0, off_step} >= (ADDR_W+1)'(win_ext)))
            off_d = '0;
`ifdef TRACE_GEN_LFSR_EN
        seed_nz  = (seed == 32'd0) ? 32'd1 : seed;
        cur_lfsr = accept ? seed_nz : lfsr_q;
        lfsr_d   = {1'b0, cur_lfsr[31:1]} ^ (cur_lfsr[0] ? 32'h8020_0003 : 32'd0);
        if (cur_mode == M_RAND)
            addr_d = cur_base + ADDR_W'(cur_lfsr[15:0] & (cur_window - 16'd1));
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            mode_q        <= 2'd0;
            base_q        <= '0;
            offset_q      <= '0;
            mem_addr_q    <= '0;
            stride_q      <= 16'd0;
            window_q      <= 16'd0;
            remaining_q   <= 16'd0;
            gap_q         <= 4'd0;
            gap_cnt_q     <= 4'd0;
            issued_q      <= '0;
            trace_ready_q <= 1'b0;
            done_q        <= 1'b0;
`ifdef TRACE_GEN_LFSR_EN
            lfsr_q        <= 32'd1;
`endif
        end else begin
            trace_ready_q <= emit;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        mode_q      <= mode;
                        base_q      <= base_addr;
                        stride_q    <= stride;
                        window_q    <= window;
                        gap_q       <= gap;
                        remaining_q <= count;
                        offset_q    <= '0;
                        issued_q    <= '0;
                        done_q      <= (count == 16'd0);
                        state_q     <= (count == 16'd0) ? S_DONE : S_ISSUE;
`ifdef TRACE_GEN_LFSR_EN
                        lfsr_q      <= seed_nz;
`endif
                    end
                end
                S_ISSUE: begin
                    if (trace_ready_q) begin
                        if (remaining_q == 16'd0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (gap_q != 4'd0) begin
                            state_q   <= S_GAP;
                            gap_cnt_q <= gap_q;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == 4'd1) state_q <= S_ISSUE;
                    else                   gap_cnt_q <= gap_cnt_q - 4'd1;
                end
                default: state_q <= S_IDLE;
            endcase
            // Emission overrides the descriptor defaults written on the start edge.
            if (emit) begin
                mem_addr_q  <= addr_d;
                offset_q    <= off_d;
                remaining_q <= cur_remaining - 16'd1;
                issued_q    <= accept ? CNT_W'(1)
                             : ((&issued_q) ? issued_q : issued_q + CNT_W'(1));
`ifdef TRACE_GEN_LFSR_EN
                lfsr_q      <= lfsr_d;
`endif
            end
        end
    end

    assign trace_ready = trace_ready_q;
    assign mem_addr    = mem_addr_q;
    assign busy        = (state_q == S_ISSUE) || (state_q == S_GAP);
    assign done        = done_q;
    assign issued      = issued_q;
endmodule

// File: tb/tb_trace_gen.sv
// Directed bench for trace_gen: vector table for the address patterns plus
// hand sequences for pause/ignored start and reset mid-run.
module tb_trace_gen;
    logic        clk = 1'b0;
    logic        reset_r, start_r, pause_r;
    logic [1:0]  mode_r;
    logic [31:0] base_r, seed_r;
    logic [15:0] stride_r, window_r, count_r;
    logic [3:0]  gap_r;
    logic        trace_ready, busy, done;
    logic [31:0] mem_addr;
    logic [19:0] issued;

    int n_checks = 0;
    int n_errors = 0;

    trace_gen #(.ADDR_W(32), .CNT_W(20)) dut (
        .clk(clk), .reset(reset_r), .start(start_r), .mode(mode_r),
        .base_addr(base_r), .stride(stride_r), .window(window_r), .count(count_r),
        .gap(gap_r), .seed(seed_r), .pause(pause_r),
        .trace_ready(trace_ready), .mem_addr(mem_addr), .busy(busy), .done(done),
        .issued(issued)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]       m;
        logic [31:0]      b;
        logic [15:0]      s;
        logic [15:0]      w;
        logic [15:0]      c;
        logic [3:0]       g;
        logic [31:0]      sd;
        int               n;
        logic [5:0][31:0] a;
    } vec_t;

    vec_t        vecs[8];
    int          cap_cyc[$];
    logic [31:0] cap_addr[$];
    int          done_cyc;
    logic        busy_c1, done_c1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Start a run and record strobe cycles/addresses until done (cycle 1 = cycle after start).
    task automatic run_desc(input logic [1:0] m, input logic [31:0] b, input logic [15:0] s,
                            input logic [15:0] w, input logic [15:0] c, input logic [3:0] g,
                            input logic [31:0] sd, input int p_lo, input int p_hi, input int inj);
        cap_cyc.delete();
        cap_addr.delete();
        done_cyc = -1;
        mode_r = m; base_r = b; stride_r = s; window_r = w; count_r = c; gap_r = g; seed_r = sd;
        pause_r = 1'b0;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        for (int cyc = 1; cyc <= 300; cyc++) begin
            if (cyc == 1) begin
                busy_c1 = busy;
                done_c1 = done;
            end
            if (trace_ready) begin
                cap_cyc.push_back(cyc);
                cap_addr.push_back(mem_addr);
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tick();
            pause_r = (cyc + 1 >= p_lo) && (cyc + 1 <= p_hi);
            if (cyc + 1 == inj) begin
                start_r  = 1'b1;
                base_r   = 32'h9000;
                count_r  = 16'd1;
            end else begin
                start_r = 1'b0;
            end
        end
        start_r = 1'b0;
        pause_r = 1'b0;
    endtask

    initial begin
        vecs[0] = '{2'd0, 32'h1000, 16'h4, 16'h0, 16'd4, 4'd0, 32'd0, 4,
                    {32'h0, 32'h0, 32'h100C, 32'h1008, 32'h1004, 32'h1000}};
        vecs[1] = '{2'd1, 32'h2000, 16'h40, 16'h100, 16'd6, 4'd0, 32'd0, 6,
                    {32'h2040, 32'h2000, 32'h20C0, 32'h2080, 32'h2040, 32'h2000}};
`ifdef TRACE_GEN_LFSR_EN
        vecs[2] = '{2'd2, 32'h3000, 16'h4, 16'h100, 16'd2, 4'd0, 32'd0, 2,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h3003, 32'h3001}};
        vecs[7] = '{2'd2, 32'h0, 16'h20, 16'h10, 16'd3, 4'd0, 32'hACE1, 3,
                    {32'h0, 32'h0, 32'h0, 32'hA, 32'h3, 32'h1}};
`else
        vecs[2] = '{2'd2, 32'h3000, 16'h4, 16'h100, 16'd2, 4'd0, 32'd0, 2,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h3004, 32'h3000}};
        vecs[7] = '{2'd2, 32'h0, 16'h20, 16'h10, 16'd3, 4'd0, 32'hACE1, 3,
                    {32'h0, 32'h0, 32'h0, 32'h40, 32'h20, 32'h0}};
`endif
        vecs[3] = '{2'd0, 32'h1234, 16'h4, 16'h0, 16'd0, 4'd0, 32'd0, 0,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
        vecs[4] = '{2'd0, 32'hFFFF_FFFC, 16'h8, 16'h0, 16'd2, 4'd0, 32'd0, 2,
                    {32'h0, 32'h0, 32'h0, 32'h0, 32'h0000_0004, 32'hFFFF_FFFC}};
        vecs[5] = '{2'd3, 32'h500, 16'h10, 16'h0, 16'd3, 4'd1, 32'd0, 3,
                    {32'h0, 32'h0, 32'h0, 32'h520, 32'h510, 32'h500}};
        vecs[6] = '{2'd1, 32'h4000, 16'h8000, 16'h0, 16'd3, 4'd3, 32'd0, 3,
                    {32'h0, 32'h0, 32'h0, 32'h4000, 32'hC000, 32'h4000}};

        reset_r = 1'b0; start_r = 1'b0; pause_r = 1'b0; mode_r = 2'd0;
        base_r = 32'd0; seed_r = 32'd0; stride_r = 16'd0; window_r = 16'd0;
        count_r = 16'd0; gap_r = 4'd0;
        repeat (3) tick();
        chk("reset_trace_ready", trace_ready, 0);
        chk("reset_mem_addr", mem_addr, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_issued", issued, 0);
        reset_r = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_desc(vecs[i].m, vecs[i].b, vecs[i].s, vecs[i].w, vecs[i].c, vecs[i].g,
                     vecs[i].sd, 0, -1, -1);
            chk($sformatf("v%0d_nstrobes", i), cap_cyc.size(), vecs[i].n);
            for (int k = 0; k < vecs[i].n && k < cap_cyc.size(); k++) begin
                chk($sformatf("v%0d_addr%0d", i, k), cap_addr[k], vecs[i].a[k]);
                chk($sformatf("v%0d_cyc%0d", i, k), cap_cyc[k], 1 + k * (vecs[i].g + 1));
            end
            chk($sformatf("v%0d_done_cyc", i), done_cyc,
                (vecs[i].n == 0) ? 1 : (vecs[i].n - 1) * (vecs[i].g + 1) + 2);
            chk($sformatf("v%0d_busy_c1", i), busy_c1, (vecs[i].n > 0) ? 1 : 0);
            chk($sformatf("v%0d_done_c1", i), done_c1, (vecs[i].n > 0) ? 0 : 1);
            chk($sformatf("v%0d_issued", i), issued, vecs[i].n);
            chk($sformatf("v%0d_busy_end", i), busy, 0);
            if (vecs[i].n > 0)
                chk($sformatf("v%0d_addr_hold", i), mem_addr, vecs[i].a[vecs[i].n - 1]);
        end

        // gap 2, pause over cycles 3..7, stray start in cycle 2
        run_desc(2'd0, 32'h7000, 16'h10, 16'h0, 16'd3, 4'd2, 32'd0, 3, 7, 2);
        chk("pause_nstrobes", cap_cyc.size(), 3);
        if (cap_cyc.size() == 3) begin
            chk("pause_cyc0", cap_cyc[0], 1);
            chk("pause_cyc1", cap_cyc[1], 9);
            chk("pause_cyc2", cap_cyc[2], 12);
            chk("pause_addr0", cap_addr[0], 32'h7000);
            chk("pause_addr1", cap_addr[1], 32'h7010);
            chk("pause_addr2", cap_addr[2], 32'h7020);
        end
        chk("pause_done_cyc", done_cyc, 13);
        chk("pause_issued", issued, 3);

        mode_r = 2'd0; base_r = 32'h6000; stride_r = 16'h4; window_r = 16'h0;
        count_r = 16'd10; gap_r = 4'd0;
        start_r = 1'b1;
        tick();
        start_r = 1'b0;
        chk("rst_s0_ready", trace_ready, 1);
        chk("rst_s0_addr", mem_addr, 32'h6000);
        tick();
        chk("rst_s1_addr", mem_addr, 32'h6004);
        chk("rst_s1_issued", issued, 2);
        reset_r = 1'b0;
        tick();
        chk("rst_trace_ready", trace_ready, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_issued", issued, 0);
        reset_r = 1'b1;
        tick();
        chk("rst_idle_busy", busy, 0);
        chk("rst_idle_ready", trace_ready, 0);
        run_desc(2'd0, 32'h6000, 16'h4, 16'h0, 16'd10, 4'd0, 32'd0, 0, -1, -1);
        chk("restart_nstrobes", cap_cyc.size(), 10);
        if (cap_cyc.size() > 0) chk("restart_addr0", cap_addr[0], 32'h6000);
        chk("restart_done_cyc", done_cyc, 11);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
